// File: rtl/pfifo_pkg.sv
// pfifo_pkg: shared FSM encoding and geometry constants for the parallel byte FIFO and its pop sequencer
package pfifo_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pfifo_state_t;
    localparam int PFIFO_LANES  = 32;
    localparam int PFIFO_BYTE_W = 8;
    localparam int PFIFO_AMT_W  = 5;
    localparam int PFIFO_DEPTH  = 96;
endpackage

// File: rtl/pfifo_out_reg.sv
// pfifo_out_reg: one-entry valid/ready output register holding a popped chunk (data, amount, last)
//  clk, rst_n           clock, asynchronous active-low reset
//  clear                drop the held entry (abort)
//  load                 capture d_data/d_amount/d_last; wins over ready
//  ready                downstream accepts the held entry
//  valid/data/amount/last  held entry
//  free_next            entry will be free at the next edge
module pfifo_out_reg #(
    parameter int DATA_W = 256,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d_data,
    input  logic [AMT_W-1:0]  d_amount,
    input  logic              d_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [AMT_W-1:0]  amount,
    output logic              last,
    output logic              free_next
);
    assign free_next = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            data   <= '0;
            amount <= '0;
            last   <= 1'b0;
        end else begin
            valid <= clear ? 1'b0 : load ? 1'b1 : ready ? 1'b0 : valid;
            if (load) begin
                data   <= d_data;
                amount <= d_amount;
                last   <= d_last;
            end
        end
    end
endmodule

// File: rtl/pfifo_pop_sequencer.sv
// pfifo_pop_sequencer: read-side controller splitting a job into FIFO pops of at most job_chunk+1 bytes
//  i_core_clk, i_rx_rstn  clock, asynchronous active-low reset
//  job_valid/job_ready    job handshake; job_len bytes (0 allowed), job_chunk = max bytes per pop - 1
//  abort                  synchronous flush of the current job, no done pulse
//  PopPermit/PopAmount    pop request to the FIFO (amount = bytes - 1)
//  PopEnable/PopData      FIFO accepted the pop this cycle, LSB-aligned bytes
//  out_*                  one-entry valid/ready output of popped chunks, out_last on the final one
//  busy, done             not idle; one-cycle completion pulse
//  underrun_cnt           present only with PFIFO_POP_SEQ_STATS_EN: saturating count of
//                         cycles with PopPermit=1 and PopEnable=0, cleared on job acceptance
module pfifo_pop_sequencer
    import pfifo_pkg::*;
#(
    parameter int DATA_W = PFIFO_LANES * PFIFO_BYTE_W,
    parameter int AMT_W  = PFIFO_AMT_W,
    parameter int LEN_W  = 16
) (
    input  logic              i_core_clk,
    input  logic              i_rx_rstn,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [AMT_W-1:0]  job_chunk,
    input  logic              abort,
    output logic              PopPermit,
    output logic [AMT_W-1:0]  PopAmount,
    input  logic              PopEnable,
    input  logic [DATA_W-1:0] PopData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amount,
    output logic              out_last,
`ifdef PFIFO_POP_SEQ_STATS_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              busy,
    output logic              done
);
    pfifo_state_t     state, state_nx;
    logic [LEN_W-1:0] remaining, rem_m1, pop_len;
    logic [AMT_W-1:0] chunk_q;
    logic             free_next, accept, pop_fire, last_pop;

    assign rem_m1    = remaining - LEN_W'(1);
    assign PopAmount = (state == POP) ? ((rem_m1 < LEN_W'(chunk_q)) ? rem_m1[AMT_W-1:0] : chunk_q) : '0;
    assign pop_len   = LEN_W'(PopAmount) + LEN_W'(1);
    assign last_pop  = remaining == pop_len;
    assign PopPermit = (state == POP) && free_next;
    // an unrequested PopEnable is a FIFO protocol error and is simply ignored
    assign pop_fire  = PopPermit && PopEnable;
    assign job_ready = state == IDLE;
    assign accept    = job_valid && job_ready && !abort;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? ((job_len == '0) ? DONE : POP) : IDLE;
            POP:     state_nx = (pop_fire && last_pop) ? DRAIN : POP;
            DRAIN:   state_nx = (out_valid && out_ready && out_last) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state     <= IDLE;
            remaining <= '0;
            chunk_q   <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                remaining <= '0;
            end else if (accept) begin
                remaining <= job_len;
                chunk_q   <= job_chunk;
            end else if (pop_fire) begin
                remaining <= remaining - pop_len;
            end
        end
    end

    pfifo_out_reg #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_out (
        .clk       (i_core_clk),
        .rst_n     (i_rx_rstn),
        .clear     (abort),
        .load      (pop_fire && !abort),
        .d_data    (PopData),
        .d_amount  (PopAmount),
        .d_last    (last_pop),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .amount    (out_amount),
        .last      (out_last),
        .free_next (free_next)
    );

`ifdef PFIFO_POP_SEQ_STATS_EN
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn)
            underrun_cnt <= '0;
        else if (accept)
            underrun_cnt <= '0;
        else if (PopPermit && !PopEnable && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

    a_no_unrequested_pop: assert property (@(posedge i_core_clk) disable iff (!i_rx_rstn) PopEnable |-> PopPermit);
endmodule

// File: tb/tb_pfifo_pop_sequencer.sv
// tb_pfifo_pop_sequencer: directed and randomized jobs checked against a chunk-level reference model
module tb_pfifo_pop_sequencer;
    import pfifo_pkg::*;

    logic         i_core_clk = 1'b0;
    logic         i_rx_rstn = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [15:0]  job_len = '0;
    logic [4:0]   job_chunk = '0;
    logic         abort = 1'b0;
    logic         PopPermit;
    logic [4:0]   PopAmount;
    logic         PopEnable = 1'b0;
    logic [255:0] PopData = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic [4:0]   out_amount;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef PFIFO_POP_SEQ_STATS_EN
    logic [15:0]  underrun_cnt;
`endif

    pfifo_pop_sequencer dut (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_len    (job_len),
        .job_chunk  (job_chunk),
        .abort      (abort),
        .PopPermit  (PopPermit),
        .PopAmount  (PopAmount),
        .PopEnable  (PopEnable),
        .PopData    (PopData),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_amount (out_amount),
        .out_last   (out_last),
`ifdef PFIFO_POP_SEQ_STATS_EN
        .underrun_cnt (underrun_cnt),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 i_core_clk = ~i_core_clk;

    int checks = 0, failures = 0;
    // reference model: job progress in bytes, output slot contents, completion pulse
    int           m_rem = 0, m_chunk = 0, m_oamt = 0, ucnt = 0;
    bit           m_busy = 0, m_done = 0, m_ov = 0, m_olast = 0;
    logic [255:0] m_odata = '0;
    // FIFO model and observations of the DUT
    int fifo_cnt = 0, rd_idx = 0, cyc = 0;
    int done_seen = 0, permit_seen = 0, obs_bytes = 0, last_pe_cyc = 0, done_cyc = 0;
    int obs_amt[$];

    function automatic logic [7:0] byte_at(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_chunk = 0; m_oamt = 0; ucnt = 0;
        m_busy = 0; m_done = 0; m_ov = 0; m_olast = 0;
    endtask

    // one clock cycle: drive at negedge, check, answer pops like a FIFO, advance the model at posedge
    task automatic step(input bit rdy, input bit ab, input bit jv, input int jl, input int jc, input int arrive);
        int amt;
        bit permit, pe, acc, done_n, busy_n;
        logic [255:0] w;
        out_ready = rdy; abort = ab; job_valid = jv; job_len = 16'(jl); job_chunk = 5'(jc);
        PopEnable = 1'b0; PopData = '0;
        #1;
        cyc++;
        permit = m_rem > 0 && (!m_ov || rdy);
        amt = ((m_rem < m_chunk + 1) ? m_rem : m_chunk + 1) - 1;
        chk("job_ready", job_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("out_valid", out_valid, m_ov);
        chk("PopPermit", PopPermit, permit);
        if (m_ov) begin
            chk("out_amount", out_amount, m_oamt);
            chk("out_last", out_last, m_olast);
            chk("out_data", out_data, m_odata);
        end
        if (permit) chk("PopAmount", PopAmount, amt);
`ifdef PFIFO_POP_SEQ_STATS_EN
        chk("underrun_cnt", underrun_cnt, ucnt);
`endif
        if (done) begin done_seen++; done_cyc = cyc; end
        if (PopPermit) permit_seen++;
        if (out_valid && out_ready) obs_bytes += int'(out_amount) + 1;
        pe = permit && fifo_cnt >= amt + 1;
        w = '0;
        if (pe) begin
            for (int i = 0; i < 32; i++) w[8*i +: 8] = (i <= amt) ? byte_at(rd_idx + i) : 8'($urandom);
            obs_amt.push_back(int'(PopAmount));
            last_pe_cyc = cyc;
        end
        PopEnable = pe; PopData = w;
        @(posedge i_core_clk);
        acc = !m_busy && jv && !ab;
        if (acc) ucnt = 0;
        else if (permit && !pe && ucnt < 65535) ucnt++;
        if (pe) begin fifo_cnt -= amt + 1; rd_idx += amt + 1; end
        if (ab) begin
            m_busy = 0; m_rem = 0; m_ov = 0; m_done = 0;
        end else begin
            done_n = (acc && jl == 0) || (m_ov && rdy && m_olast);
            busy_n = m_done ? 1'b0 : (acc ? 1'b1 : m_busy);
            if (acc) begin m_rem = jl; m_chunk = jc; end
            if (pe) begin
                m_ov = 1; m_oamt = amt; m_olast = (m_rem == amt + 1); m_odata = w; m_rem -= amt + 1;
            end else if (m_ov && rdy) begin
                m_ov = 0;
            end
            m_done = done_n; m_busy = busy_n;
        end
        fifo_cnt = (fifo_cnt + arrive > PFIFO_DEPTH) ? PFIFO_DEPTH : fifo_cnt + arrive;
        @(negedge i_core_clk);
    endtask

    // rdy_mode: 0 always ready, 1 alternating, 2 random
    task automatic run_job(input int len, input int chunk, input int rdy_mode, input int max_arrive, input int ab_pct);
        int n = 0;
        step(1'b1, 1'b0, 1'b1, len, chunk, $urandom_range(0, max_arrive));
        while (m_busy && n < 3000) begin
            step(rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? n[0] == 1'b0 : 1'($urandom),
                 $urandom_range(0, 99) < ab_pct, 1'b0, 0, 0, $urandom_range(0, max_arrive));
            n++;
        end
        chk("job_finished", m_busy, 1'b0);
    endtask

    initial begin
        int d0, p0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_PopPermit", PopPermit, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge i_core_clk);
        i_rx_rstn = 1'b1;

        // 70 bytes in 32-byte pops from a full FIFO
        fifo_cnt = 96; obs_amt.delete();
        step(1'b1, 1'b0, 1'b1, 70, 31, 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("t1_num_pops", obs_amt.size(), 3);
        chk("t1_amt0", obs_amt[0], 31);
        chk("t1_amt1", obs_amt[1], 31);
        chk("t1_amt2", obs_amt[2], 5);
        chk("t1_done_latency", done_cyc - last_pe_cyc, 2);
        chk("t1_bytes", obs_bytes, 70);

        // zero-length job
        d0 = done_seen; p0 = permit_seen;
        step(1'b1, 1'b0, 1'b1, 0, 7, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("t2_done_once", done_seen - d0, 1);
        chk("t2_no_permit", permit_seen - p0, 0);

        // FIFO short of data: PopAmount held while waiting for bytes
        fifo_cnt = 10; obs_amt.delete();
        step(1'b1, 1'b0, 1'b1, 40, 15, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 0, i == 4 ? 6 : 0);
        while (m_busy && cyc < 500) step(1'b1, 1'b0, 1'b0, 0, 0, 16);
        chk("t3_first_amt", obs_amt[0], 15);

        // backpressure toggling
        fifo_cnt = 96; obs_bytes = 0;
        run_job(64, 15, 1, 0, 0);
        chk("t4_bytes", obs_bytes, 64);

        // abort on the second pop
        fifo_cnt = 96; d0 = done_seen;
        step(1'b1, 1'b0, 1'b1, 96, 31, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("t5_no_done", done_seen - d0, 0);

        // asynchronous reset mid-job
        fifo_cnt = 96;
        step(1'b0, 1'b0, 1'b1, 80, 7, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        #2 i_rx_rstn = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data", out_data, '0);
        chk("t6_out_amount", out_amount, '0);
        chk("t6_out_last", out_last, 1'b0);
        chk("t6_PopPermit", PopPermit, 1'b0);
        chk("t6_job_ready", job_ready, 1'b1);
        model_reset();
        @(negedge i_core_clk);
        i_rx_rstn = 1'b1;
        fifo_cnt = 96; obs_bytes = 0;
        run_job(50, 9, 0, 0, 0);
        chk("t6_next_job_bytes", obs_bytes, 50);

        // randomized jobs with backpressure, FIFO starvation and occasional aborts
        for (int j = 0; j < 30; j++)
            run_job($urandom_range(0, 150), $urandom_range(0, 31), 2, $urandom_range(4, 40), j % 5 == 4 ? 3 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
